// File: rtl/tqvp_bus_initiator_if.sv
// Bundle of signals around the TinyQV peripheral bus initiator.
//   cmd_*  : command request channel (valid/ready), offered by the host side
//   rsp_*  : response channel (valid/ready), one response per command
//   address, data_in, data_write_n, data_read_n : strobed bus toward the peripheral
//   data_out, data_ready                        : read return from the peripheral
// Modport master is taken by the initiator; slave by whoever drives commands,
// consumes responses and models the peripheral.
interface tqvp_bus_initiator_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [1:0]  cmd_size;
  logic [5:0]  cmd_addr;
  logic [31:0] cmd_wdata;

  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  logic [5:0]  address;
  logic [31:0] data_in;
  logic [1:0]  data_write_n;
  logic [1:0]  data_read_n;
  logic [31:0] data_out;
  logic        data_ready;

  modport master (
    input  cmd_valid, cmd_write, cmd_size, cmd_addr, cmd_wdata,
    input  rsp_ready, data_out, data_ready,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
    output address, data_in, data_write_n, data_read_n
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_size, cmd_addr, cmd_wdata,
    output rsp_ready, data_out, data_ready,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
    input  address, data_in, data_write_n, data_read_n
  );
endinterface

// File: rtl/tqvp_bus_initiator.sv
// Initiator end of the TinyQV peripheral bus. Accepts one command at a time,
// drives a correctly timed write or read strobe toward a single peripheral
// and returns one response per command.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   b           : tqvp_bus_initiator_if.master (command, response, peripheral bus)
//   busy        : high whenever the initiator is not idle
//   err_count   : saturating count of error responses (illegal size, read timeout)
module tqvp_bus_initiator #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int ERRCNT_W       = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  tqvp_bus_initiator_if.master b,
  output logic                busy,
  output logic [ERRCNT_W-1:0] err_count
);

  typedef enum logic [1:0] {IDLE, WR, RD, RESP} state_t;

  localparam logic [1:0] STROBE_IDLE = 2'b11;
  localparam logic [7:0] WAIT_LAST   = 8'(TIMEOUT_CYCLES - 1);

  state_t     state, state_nxt;
  logic [7:0] wait_cnt;
  logic       timeout;
  logic       err_set;

  // Zero-extend data to the width selected by a size code.
  function automatic logic [31:0] size_mask(input logic [31:0] d, input logic [1:0] sz);
    case (sz)
      2'b00:   size_mask = {24'h0, d[7:0]};
      2'b01:   size_mask = {16'h0, d[15:0]};
      default: size_mask = d;
    endcase
  endfunction

  assign b.cmd_ready = (state == IDLE);
  assign busy        = (state != IDLE);

  // Last permitted RD cycle; data_ready in this same cycle still wins.
  assign timeout = (wait_cnt == WAIT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state is updated with <= so every register samples
    // the pre-edge values regardless of statement order.
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    // NOTE: defaults first so no path through the case leaves a variable
    // unassigned, which would otherwise infer a latch.
    state_nxt = state;
    err_set   = 1'b0;
    case (state)
      IDLE: if (b.cmd_valid) begin
        if (b.cmd_size == 2'b11) begin
          state_nxt = RESP;
          err_set   = 1'b1;
        end else begin
          state_nxt = b.cmd_write ? WR : RD;
        end
      end
      WR:   state_nxt = RESP;
      RD: if (b.data_ready || timeout) begin
        state_nxt = RESP;
        err_set   = !b.data_ready;
      end
      RESP: if (b.rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Bus and response registers. The strobe register also remembers the size
  // of the read in flight, used to mask the returned data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b.address      <= '0;
      b.data_in      <= '0;
      b.data_write_n <= STROBE_IDLE;
      b.data_read_n  <= STROBE_IDLE;
      b.rsp_valid    <= 1'b0;
      b.rsp_rdata    <= '0;
      b.rsp_err      <= 1'b0;
      wait_cnt       <= '0;
    end else begin
      case (state)
        IDLE: if (b.cmd_valid) begin
          if (b.cmd_size == 2'b11) begin
            b.rsp_valid <= 1'b1;
            b.rsp_err   <= 1'b1;
            b.rsp_rdata <= '0;
          end else begin
            b.address <= b.cmd_addr;
            if (b.cmd_write) begin
              b.data_write_n <= b.cmd_size;
              b.data_in      <= size_mask(b.cmd_wdata, b.cmd_size);
            end else begin
              b.data_read_n <= b.cmd_size;
              b.data_in     <= '0;
              wait_cnt      <= '0;
            end
          end
        end
        WR: begin
          b.data_write_n <= STROBE_IDLE;
          b.rsp_valid    <= 1'b1;
          b.rsp_err      <= 1'b0;
          b.rsp_rdata    <= '0;
        end
        RD: begin
          if (b.data_ready) begin
            b.data_read_n <= STROBE_IDLE;
            b.rsp_valid   <= 1'b1;
            b.rsp_err     <= 1'b0;
            b.rsp_rdata   <= size_mask(b.data_out, b.data_read_n);
          end else if (timeout) begin
            b.data_read_n <= STROBE_IDLE;
            b.rsp_valid   <= 1'b1;
            b.rsp_err     <= 1'b1;
            b.rsp_rdata   <= '0;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        RESP: if (b.rsp_ready) b.rsp_valid <= 1'b0;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                           err_count <= '0;
    else if (err_set && err_count != '1)  err_count <= err_count + 1'b1;
  end

endmodule

// File: tb/tb_tqvp_bus_initiator.sv
// Self-checking bench for tqvp_bus_initiator: table of single transactions
// plus hand-written sequences for backpressure, error saturation and
// asynchronous reset in the middle of a read.
module tb_tqvp_bus_initiator;

  logic       clk;
  logic       rst_n;
  logic       busy;
  logic [7:0] err_count;

  tqvp_bus_initiator_if b ();

  tqvp_bus_initiator #(.TIMEOUT_CYCLES(16), .ERRCNT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .b         (b),
    .busy      (busy),
    .err_count (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic [5:0]  addr;
    logic [31:0] wdata;
    logic [31:0] dout;        // data_out returned once data_ready is raised
    int          delay;       // RD cycles with data_ready low before it rises
    int          exp_strobe;  // cycles with a strobe active
    int          exp_lat;     // cycles from accept edge to rsp_valid
    logic [31:0] exp_din;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs [10];
  int   checks = 0;
  int   errors = 0;
  int   exp_ec = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // One full transaction including response handshake.
  task automatic run_vec(input vec_t v, input string tag);
    int   strobes = 0;
    int   rd_k = 0;
    int   lat = 0;
    logic bad = 1'b0;
    @(negedge clk);
    b.cmd_valid = 1'b1;
    b.cmd_write = v.wr;
    b.cmd_size  = v.size;
    b.cmd_addr  = v.addr;
    b.cmd_wdata = v.wdata;
    b.data_ready = v.wr;
    b.data_out  = 32'hFFFF_FFFF;
    check({tag, " cmd_ready"}, 32'(b.cmd_ready), 32'd1);
    @(posedge clk);
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      b.cmd_valid = 1'b0;
      if (b.rsp_valid) begin
        lat = n;
        break;
      end
      if (b.data_write_n != 2'b11 || b.data_read_n != 2'b11) begin
        strobes++;
        if (v.wr) bad |= (b.data_write_n != v.size) || (b.data_read_n != 2'b11);
        else      bad |= (b.data_read_n != v.size) || (b.data_write_n != 2'b11);
        if (strobes == 1) begin
          check({tag, " address"}, 32'(b.address), 32'(v.addr));
          check({tag, " data_in"}, b.data_in, v.exp_din);
        end
        if (!v.wr) begin
          rd_k++;
          b.data_ready = (rd_k > v.delay);
          b.data_out   = b.data_ready ? v.dout : 32'hFFFF_FFFF;
        end
      end
    end
    if (v.exp_err && exp_ec != 255) exp_ec++;
    check({tag, " strobe_cycles"}, 32'(strobes), 32'(v.exp_strobe));
    check({tag, " strobe_code"}, 32'(bad), 32'd0);
    check({tag, " latency"}, 32'(lat), 32'(v.exp_lat));
    check({tag, " rsp_rdata"}, b.rsp_rdata, v.exp_rdata);
    check({tag, " rsp_err"}, 32'(b.rsp_err), 32'(v.exp_err));
    check({tag, " err_count"}, 32'(err_count), 32'(exp_ec));
    b.rsp_ready  = 1'b1;
    b.data_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    b.rsp_ready = 1'b0;
    check({tag, " rsp_valid_clr"}, 32'(b.rsp_valid), 32'd0);
    check({tag, " cmd_ready_back"}, 32'(b.cmd_ready), 32'd1);
  endtask

  initial begin
    //          wr  sz     addr    wdata          dout           dly  stb lat din            rdata          err
    vecs[0] = '{1'b1, 2'b10, 6'h18, 32'hDEADBEEF, 32'h0,         0,   1,  2,  32'hDEADBEEF, 32'h0,         1'b0};
    vecs[1] = '{1'b1, 2'b00, 6'h05, 32'hAABBCCDD, 32'h0,         0,   1,  2,  32'h000000DD, 32'h0,         1'b0};
    vecs[2] = '{1'b1, 2'b01, 6'h3F, 32'h11223344, 32'h0,         0,   1,  2,  32'h00003344, 32'h0,         1'b0};
    vecs[3] = '{1'b0, 2'b00, 6'h04, 32'h0,        32'h12345678,  0,   1,  2,  32'h0,        32'h00000078,  1'b0};
    vecs[4] = '{1'b0, 2'b01, 6'h04, 32'h0,        32'h12345678,  0,   1,  2,  32'h0,        32'h00005678,  1'b0};
    vecs[5] = '{1'b0, 2'b10, 6'h2A, 32'h0,        32'hCAFEF00D,  3,   4,  5,  32'h0,        32'hCAFEF00D,  1'b0};
    vecs[6] = '{1'b0, 2'b10, 6'h01, 32'h0,        32'h55AA55AA,  255, 16, 17, 32'h0,        32'h0,         1'b1};
    vecs[7] = '{1'b0, 2'b00, 6'h02, 32'h0,        32'hA5A5A5A5,  15,  16, 17, 32'h0,        32'h000000A5,  1'b0};
    vecs[8] = '{1'b0, 2'b11, 6'h09, 32'h0,        32'h0,         0,   0,  1,  32'h0,        32'h0,         1'b1};
    vecs[9] = '{1'b1, 2'b11, 6'h0A, 32'h12345678, 32'h0,         0,   0,  1,  32'h0,        32'h0,         1'b1};

    rst_n       = 1'b0;
    b.cmd_valid = 1'b0;
    b.cmd_write = 1'b0;
    b.cmd_size  = 2'b00;
    b.cmd_addr  = '0;
    b.cmd_wdata = '0;
    b.rsp_ready = 1'b0;
    b.data_out  = '0;
    b.data_ready = 1'b0;

    // Reset state.
    #12;
    check("reset cmd_ready", 32'(b.cmd_ready), 32'd1);
    check("reset data_write_n", 32'(b.data_write_n), 32'd3);
    check("reset data_read_n", 32'(b.data_read_n), 32'd3);
    check("reset rsp_valid", 32'(b.rsp_valid), 32'd0);
    check("reset rsp_rdata", b.rsp_rdata, 32'd0);
    check("reset rsp_err", 32'(b.rsp_err), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset err_count", 32'(err_count), 32'd0);
    check("reset address", 32'(b.address), 32'd0);
    check("reset data_in", b.data_in, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Backpressure: response held for 5 cycles while another command is offered.
    @(negedge clk);
    b.cmd_valid  = 1'b1;
    b.cmd_write  = 1'b0;
    b.cmd_size   = 2'b01;
    b.cmd_addr   = 6'h11;
    b.data_ready = 1'b1;
    b.data_out   = 32'h1234BEEF;
    @(posedge clk);
    @(negedge clk);
    b.cmd_valid = 1'b0;
    check("bp read strobe", 32'(b.data_read_n), 32'd1);
    @(negedge clk);
    check("bp rsp_valid", 32'(b.rsp_valid), 32'd1);
    check("bp rsp_rdata", b.rsp_rdata, 32'h0000BEEF);
    b.data_ready = 1'b0;
    b.cmd_valid  = 1'b1;
    b.cmd_write  = 1'b1;
    b.cmd_size   = 2'b10;
    b.cmd_addr   = 6'h22;
    b.cmd_wdata  = 32'h0BADF00D;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("bp hold%0d rsp_valid", k), 32'(b.rsp_valid), 32'd1);
      check($sformatf("bp hold%0d rsp_rdata", k), b.rsp_rdata, 32'h0000BEEF);
      check($sformatf("bp hold%0d cmd_ready", k), 32'(b.cmd_ready), 32'd0);
      check($sformatf("bp hold%0d no_strobe", k), 32'(b.data_write_n), 32'd3);
    end
    b.rsp_ready = 1'b1;
    @(negedge clk);
    b.rsp_ready = 1'b0;
    check("bp handshake rsp_valid", 32'(b.rsp_valid), 32'd0);
    check("bp handshake no_accept", 32'(b.data_write_n), 32'd3);
    check("bp handshake cmd_ready", 32'(b.cmd_ready), 32'd1);
    @(negedge clk);
    b.cmd_valid = 1'b0;
    check("bp next write strobe", 32'(b.data_write_n), 32'd2);
    check("bp next write data_in", b.data_in, 32'h0BADF00D);
    @(negedge clk);
    check("bp next write rsp_valid", 32'(b.rsp_valid), 32'd1);
    check("bp next write rsp_err", 32'(b.rsp_err), 32'd0);
    b.rsp_ready = 1'b1;
    @(negedge clk);
    b.rsp_ready = 1'b0;

    // Error counter saturation.
    for (int i = 0; i < 300; i++) run_vec(vecs[8 + (i % 2)], $sformatf("sat%0d", i));
    check("saturated err_count", 32'(err_count), 32'd255);

    // Asynchronous reset while a 32-bit read strobe is active.
    @(negedge clk);
    b.cmd_valid  = 1'b1;
    b.cmd_write  = 1'b0;
    b.cmd_size   = 2'b10;
    b.cmd_addr   = 6'h07;
    b.data_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    b.cmd_valid = 1'b0;
    check("rst_mid strobe before", 32'(b.data_read_n), 32'd2);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid data_read_n", 32'(b.data_read_n), 32'd3);
    check("rst_mid rsp_valid", 32'(b.rsp_valid), 32'd0);
    check("rst_mid err_count", 32'(err_count), 32'd0);
    check("rst_mid cmd_ready", 32'(b.cmd_ready), 32'd1);
    exp_ec = 0;
    @(negedge clk);
    rst_n = 1'b1;
    run_vec(vecs[0], "post_reset_write");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
